lpf_decimate2_packer: RTL and testbench

- Sits directly after the 8-sample/clk half-band lowpass filter.
- Decimates the filter output by 2 by keeping the even samples, and saturates each kept sample from 13 to 12 bits.
- Packs two input beats into one 8-sample output word.
- Presents packed words on a valid/ready stream through a small FWFT FIFO, with a sticky overflow flag.

---
 rtl/lpf_decimate2_packer.sv | 156 +++++++++++++++
 tb/tb_lpf_decimate2_packer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpf_decimate2_packer.sv
// Decimate-by-2 packer for the half-band lowpass output.
// Even samples of each beat are saturated to OUTBITS, two beats form one
// NSAMPS-sample word, and words are queued in a small first-word-fall-through
// FIFO with sticky overflow and misalignment flags.
//
// Output stream handshake: a word transfers on any rising edge where
// dat_valid_o && dat_ready_i. While dat_valid_o=1 and dat_ready_i=0, both
// dat_o and dat_valid_o hold steady. dat_valid_o never depends on dat_ready_i.
// The input side has no backpressure: every dat_valid_i beat is consumed.
module lpf_decimate2_packer #(
  parameter int    INBITS     = 13,
  parameter int    OUTBITS    = 12,
  parameter int    NSAMPS     = 8,
  parameter int    FIFO_DEPTH = 4,
  parameter string SATURATE   = "TRUE"
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NSAMPS-1:0][INBITS-1:0]    dat_i,
  input  logic                             dat_valid_i,
  input  logic                             sync_i,
  output logic [NSAMPS-1:0][OUTBITS-1:0]   dat_o,
  output logic                             dat_valid_o,
  input  logic                             dat_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]      fill_o,
  output logic                             overflow_o,
  output logic                             misalign_o,
  input  logic                             clr_i
);

  localparam int  HALF   = NSAMPS / 2;
  localparam int  AW     = $clog2(FIFO_DEPTH);
  localparam bit  SAT_EN = (SATURATE == "TRUE");

  typedef enum logic {PH_LOW, PH_HIGH} phase_e;
  typedef logic [NSAMPS-1:0][OUTBITS-1:0] word_t;

  // Clamp to the OUTBITS range when the discarded top bits disagree with the sign.
  function automatic logic [OUTBITS-1:0] sat_f(input logic [INBITS-1:0] x);
    logic [INBITS-OUTBITS:0] top;
    top = x[INBITS-1:OUTBITS-1];
    if (SAT_EN && !((&top) || !(|top)))
      sat_f = x[INBITS-1] ? {1'b1, {(OUTBITS-1){1'b0}}} : {1'b0, {(OUTBITS-1){1'b1}}};
    else
      sat_f = x[OUTBITS-1:0];
  endfunction

  logic [HALF-1:0][OUTBITS-1:0] kept;
  logic [HALF-1:0][OUTBITS-1:0] h_q;
  logic [HALF-1:0]              unused_odd;
  word_t                        wr_word;
  word_t                        mem [FIFO_DEPTH];
  word_t                        last_q;
  logic [AW-1:0]                wr_ptr_q, rd_ptr_q;
  logic [AW:0]                  cnt_q, cnt_d;
  phase_e                       phase_q, phase_d, beat_ph;
  logic                         ovf_q, mis_q;
  logic                         wr_req, wr_en, rd_fire, full, ovf_ev, mis_ev, h_load;

  // Keep the even samples (saturated), fold the odd ones into an unused sink.
  always_comb begin
    kept       = '0;
    unused_odd = '0;
    for (int k = 0; k < HALF; k++) begin
      kept[k]       = sat_f(dat_i[2*k]);
      unused_odd[k] = ^dat_i[2*k+1];
    end
  end

  // Phase state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) phase_q <= PH_LOW;
    else       phase_q <= phase_d;
  end

  // Phase next-state: sync forces the current beat to the low half, then toggle.
  always_comb begin
    beat_ph = phase_q;
    phase_d = phase_q;
    if (sync_i) beat_ph = PH_LOW;
    if (dat_valid_i) phase_d = (beat_ph == PH_LOW) ? PH_HIGH : PH_LOW;
  end

  assign h_load  = dat_valid_i && (beat_ph == PH_LOW);
  assign wr_req  = dat_valid_i && (beat_ph == PH_HIGH);
  assign mis_ev  = dat_valid_i && sync_i && (phase_q == PH_HIGH);
  assign full    = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign rd_fire = dat_valid_o && dat_ready_i;
  assign wr_en   = wr_req && (!full || rd_fire);
  assign ovf_ev  = wr_req && full && !rd_fire;

  // Assemble the outgoing word: held half in the low samples, current beat above.
  always_comb begin
    wr_word = '0;
    for (int k = 0; k < HALF; k++) begin
      wr_word[k]      = h_q[k];
      wr_word[k+HALF] = kept[k];
    end
  end

  // Half-word holding register for the low-phase beat.
  always_ff @(posedge clk_i) begin
    if (rst_i)       h_q <= '0;
    else if (h_load) h_q <= kept;
  end

  // FIFO storage; contents are qualified by the occupancy count, so no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_q] <= wr_word;
  end

  // Occupancy next-state for simultaneous or single push/pop.
  always_comb begin
    cnt_d = cnt_q;
    case ({wr_en, rd_fire})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers, occupancy, and the last-read word shown while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
    end else begin
      if (wr_en)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_fire) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= mem[rd_ptr_q];
      end
      cnt_q <= cnt_d;
    end
  end

  // Sticky flags: a new event in the clearing cycle wins over clr_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q && !clr_i) || ovf_ev;
      mis_q <= (mis_q && !clr_i) || mis_ev;
    end
  end

  assign dat_valid_o = (cnt_q != '0);
  assign dat_o       = dat_valid_o ? mem[rd_ptr_q] : last_q;
  assign fill_o      = cnt_q;
  assign overflow_o  = ovf_q;
  assign misalign_o  = mis_q;

endmodule

// File: tb/tb_lpf_decimate2_packer.sv
// Bench for lpf_decimate2_packer: directed scenarios plus a randomized run,
// checked against a queue-based reference of the decimate/pack/FIFO behaviour.
module tb_lpf_decimate2_packer;

  localparam int INBITS     = 13;
  localparam int OUTBITS    = 12;
  localparam int NSAMPS     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int HALF       = NSAMPS / 2;
  localparam int FW         = $clog2(FIFO_DEPTH) + 1;
  localparam int W          = NSAMPS * OUTBITS;
  localparam int MAXV       = (1 << (OUTBITS-1)) - 1;
  localparam int MINV       = -(1 << (OUTBITS-1));

  logic                           clk_i = 1'b0;
  logic                           rst_i = 1'b0;
  logic [NSAMPS-1:0][INBITS-1:0]  dat_i = '0;
  logic                           dat_valid_i = 1'b0;
  logic                           sync_i = 1'b0;
  logic                           dat_ready_i = 1'b0;
  logic                           clr_i = 1'b0;
  logic [NSAMPS-1:0][OUTBITS-1:0] dat_o, dat_o_ns;
  logic                           dat_valid_o, dat_valid_ns;
  logic [FW-1:0]                  fill_o, fill_ns;
  logic                           overflow_o, overflow_ns, misalign_o, misalign_ns;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  logic [W-1:0]           exp_q[$];
  logic [W-1:0]           m_last;
  logic [HALF*OUTBITS-1:0] m_h;
  bit                     m_phase, m_ovf, m_mis;

  lpf_decimate2_packer #(.INBITS(INBITS), .OUTBITS(OUTBITS), .NSAMPS(NSAMPS),
    .FIFO_DEPTH(FIFO_DEPTH), .SATURATE("TRUE")) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .dat_i(dat_i), .dat_valid_i(dat_valid_i),
    .sync_i(sync_i), .dat_o(dat_o), .dat_valid_o(dat_valid_o),
    .dat_ready_i(dat_ready_i), .fill_o(fill_o), .overflow_o(overflow_o),
    .misalign_o(misalign_o), .clr_i(clr_i));

  lpf_decimate2_packer #(.INBITS(INBITS), .OUTBITS(OUTBITS), .NSAMPS(NSAMPS),
    .FIFO_DEPTH(FIFO_DEPTH), .SATURATE("FALSE")) u_nosat (
    .clk_i(clk_i), .rst_i(rst_i), .dat_i(dat_i), .dat_valid_i(dat_valid_i),
    .sync_i(sync_i), .dat_o(dat_o_ns), .dat_valid_o(dat_valid_ns),
    .dat_ready_i(dat_ready_i), .fill_o(fill_ns), .overflow_o(overflow_ns),
    .misalign_o(misalign_ns), .clr_i(clr_i));

  // Clock generation.
  always #5 clk_i = ~clk_i;

  // Arithmetic clamp into the signed OUTBITS range.
  function automatic logic [OUTBITS-1:0] ref_sat(input logic [INBITS-1:0] x, input bit sat);
    int v;
    v = int'($signed(x));
    if (sat) begin
      if (v > MAXV) v = MAXV;
      else if (v < MINV) v = MINV;
    end
    return v[OUTBITS-1:0];
  endfunction

  // Word packed from two ramp beats b0,b1 where sample j of beat b is 8b+j.
  function automatic logic [W-1:0] ramp_word(input int b0, input int b1);
    logic [W-1:0] w;
    for (int k = 0; k < HALF; k++) begin
      w[k*OUTBITS +: OUTBITS]        = OUTBITS'(NSAMPS*b0 + 2*k);
      w[(k+HALF)*OUTBITS +: OUTBITS] = OUTBITS'(NSAMPS*b1 + 2*k);
    end
    return w;
  endfunction

  // Reference model: apply the current inputs at a rising edge.
  task automatic model_edge();
    bit rd, full_b, ph, ovf_ev, mis_ev;
    logic [HALF*OUTBITS-1:0] kh;
    if (rst_i) begin
      exp_q.delete();
      m_last = '0; m_h = '0; m_phase = 0; m_ovf = 0; m_mis = 0;
      return;
    end
    full_b = (exp_q.size() == FIFO_DEPTH);
    rd     = (exp_q.size() != 0) && dat_ready_i;
    ovf_ev = 0; mis_ev = 0;
    if (rd) m_last = exp_q.pop_front();
    if (dat_valid_i) begin
      for (int k = 0; k < HALF; k++) kh[k*OUTBITS +: OUTBITS] = ref_sat(dat_i[2*k], 1'b1);
      ph = sync_i ? 1'b0 : m_phase;
      if (sync_i && m_phase) mis_ev = 1;
      if (!ph) m_h = kh;
      else if (!full_b || rd) exp_q.push_back({kh, m_h});
      else ovf_ev = 1;
      m_phase = !ph;
    end
    m_ovf = (m_ovf && !clr_i) || ovf_ev;
    m_mis = (m_mis && !clr_i) || mis_ev;
  endtask

  // One clock: edge, model update, then settle before sampling.
  task automatic clk_cycle();
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic ramp_beat(input int b, input bit sync);
    for (int j = 0; j < NSAMPS; j++) dat_i[j] = INBITS'(NSAMPS*b + j);
    dat_valid_i = 1'b1;
    sync_i      = sync;
  endtask

  task automatic idle_inputs();
    dat_valid_i = 1'b0; sync_i = 1'b0; clr_i = 1'b0; dat_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    clk_cycle();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (dat_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", dat_valid_o); end
    checks++; if (dat_o !== '0) begin failures++; $display("FAIL reset_dat got=%h exp=0", dat_o); end
    checks++; if (fill_o !== '0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", fill_o); end
    checks++; if (overflow_o !== 1'b0 || misalign_o !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", overflow_o, misalign_o); end
  endtask

  task automatic test_ramp();
    logic [W-1:0] w0;
    do_reset();
    dat_ready_i = 1'b1;
    w0 = ramp_word(0, 1);
    for (int b = 0; b < 8; b++) begin
      ramp_beat(b, b == 0);
      clk_cycle();
      if (b == 0) begin
        checks++; if (dat_valid_o !== 1'b0) begin failures++; $display("FAIL ramp_early_valid got=%b exp=0", dat_valid_o); end
      end
      if (b == 1) begin
        checks++; if (dat_valid_o !== 1'b1) begin failures++; $display("FAIL ramp_word0_valid got=%b exp=1", dat_valid_o); end
        checks++; if (dat_o !== w0) begin failures++; $display("FAIL ramp_word0 got=%h exp=%h", dat_o, w0); end
      end
      checks++; if (fill_o > 1) begin failures++; $display("FAIL ramp_fill got=%0d exp<=1", fill_o); end
      checks++; if (dat_valid_o !== (exp_q.size() != 0) || fill_o !== FW'(exp_q.size())) begin
        failures++; $display("FAIL ramp_model valid=%b fill=%0d exp_fill=%0d", dat_valid_o, fill_o, exp_q.size()); end
      if (exp_q.size() != 0) begin
        checks++; if (dat_o !== exp_q[0]) begin failures++; $display("FAIL ramp_dat got=%h exp=%h", dat_o, exp_q[0]); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_saturation();
    logic [INBITS-1:0]  in_v [4];
    logic [OUTBITS-1:0] sat_v [4];
    logic [OUTBITS-1:0] raw_v [4];
    logic [W-1:0] ws, wr;
    in_v  = '{13'h0FFF, 13'h1000, 13'h07FF, 13'h1800};
    sat_v = '{12'h7FF, 12'h800, 12'h7FF, 12'h800};
    raw_v = '{12'hFFF, 12'h000, 12'h7FF, 12'h800};
    for (int k = 0; k < HALF; k++) begin
      ws[k*OUTBITS +: OUTBITS] = sat_v[k]; ws[(k+HALF)*OUTBITS +: OUTBITS] = sat_v[k];
      wr[k*OUTBITS +: OUTBITS] = raw_v[k]; wr[(k+HALF)*OUTBITS +: OUTBITS] = raw_v[k];
    end
    do_reset();
    dat_ready_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      dat_i = '0;
      for (int k = 0; k < HALF; k++) begin
        dat_i[2*k]   = in_v[k];
        dat_i[2*k+1] = 13'h0ABC;
      end
      dat_valid_i = 1'b1; sync_i = (b == 0);
      clk_cycle();
    end
    idle_inputs();
    checks++; if (dat_o !== ws) begin failures++; $display("FAIL sat_true got=%h exp=%h", dat_o, ws); end
    checks++; if (dat_o_ns !== wr) begin failures++; $display("FAIL sat_false got=%h exp=%h", dat_o_ns, wr); end
    checks++; if (dat_valid_ns !== 1'b1) begin failures++; $display("FAIL sat_false_valid got=%b exp=1", dat_valid_ns); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] got[$];
    do_reset();
    dat_ready_i = 1'b0;
    for (int b = 0; b < 20; b++) begin
      ramp_beat(b, b == 0);
      clk_cycle();
      if (b == 7) begin
        checks++; if (fill_o !== FW'(4)) begin failures++; $display("FAIL bp_fill4 got=%0d exp=4", fill_o); end
        checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL bp_no_ovf_yet got=%b exp=0", overflow_o); end
      end
      if (b == 9) begin
        checks++; if (overflow_o !== 1'b1) begin failures++; $display("FAIL bp_ovf_word5 got=%b exp=1", overflow_o); end
      end
    end
    idle_inputs();
    dat_ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (dat_valid_o) got.push_back(dat_o);
      clk_cycle();
    end
    checks++; if (got.size() != 4) begin failures++; $display("FAIL bp_drain_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      checks++; if (got[i] !== ramp_word(2*i, 2*i+1)) begin failures++; $display("FAIL bp_word%0d got=%h exp=%h", i, got[i], ramp_word(2*i, 2*i+1)); end
    end
    checks++; if (overflow_o !== 1'b1) begin failures++; $display("FAIL bp_ovf_sticky got=%b exp=1", overflow_o); end
    clr_i = 1'b1;
    clk_cycle();
    clr_i = 1'b0;
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL bp_clr got=%b exp=0", overflow_o); end
  endtask

  task automatic test_misalign();
    logic [W-1:0] got[$];
    int b;
    do_reset();
    dat_ready_i = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c < 5) ramp_beat(c, (c == 0) || (c == 3));
      else idle_inputs();
      if (dat_valid_o) got.push_back(dat_o);
      clk_cycle();
      if (c == 2) begin
        checks++; if (misalign_o !== 1'b0) begin failures++; $display("FAIL mis_early got=%b exp=0", misalign_o); end
      end
      if (c == 3) begin
        checks++; if (misalign_o !== 1'b1) begin failures++; $display("FAIL mis_set got=%b exp=1", misalign_o); end
      end
    end
    checks++; if (got.size() != 2) begin failures++; $display("FAIL mis_count got=%0d exp=2", got.size()); end
    b = 0;
    if (got.size() > 0) begin
      checks++; if (got[0] !== ramp_word(0, 1)) begin failures++; $display("FAIL mis_word0 got=%h exp=%h", got[0], ramp_word(0, 1)); end
    end
    if (got.size() > 1) begin
      checks++; if (got[1] !== ramp_word(3, 4)) begin failures++; $display("FAIL mis_word1 got=%h exp=%h", got[1], ramp_word(3, 4)); end
    end
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL mis_no_ovf got=%b exp=0", overflow_o); end
  endtask

  task automatic test_full_simul_read();
    do_reset();
    dat_ready_i = 1'b0;
    for (int b = 0; b < 9; b++) begin
      ramp_beat(b, b == 0);
      clk_cycle();
    end
    checks++; if (fill_o !== FW'(4)) begin failures++; $display("FAIL fsr_full got=%0d exp=4", fill_o); end
    ramp_beat(9, 1'b0);
    dat_ready_i = 1'b1;
    clk_cycle();
    idle_inputs();
    dat_ready_i = 1'b0;
    checks++; if (fill_o !== FW'(4)) begin failures++; $display("FAIL fsr_fill got=%0d exp=4", fill_o); end
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL fsr_ovf got=%b exp=0", overflow_o); end
    checks++; if (dat_o !== ramp_word(2, 3)) begin failures++; $display("FAIL fsr_head got=%h exp=%h", dat_o, ramp_word(2, 3)); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    dat_ready_i = 1'b0;
    ramp_beat(0, 1'b1); clk_cycle();
    ramp_beat(1, 1'b0); clk_cycle();
    ramp_beat(2, 1'b0); clk_cycle();
    idle_inputs();
    rst_i = 1'b1; clk_cycle(); rst_i = 1'b0;
    checks++; if (dat_valid_o !== 1'b0 || fill_o !== '0) begin failures++; $display("FAIL rstmid_empty valid=%b fill=%0d exp 0/0", dat_valid_o, fill_o); end
    ramp_beat(5, 1'b0); clk_cycle();
    checks++; if (dat_valid_o !== 1'b0) begin failures++; $display("FAIL rstmid_phase0 got=%b exp=0", dat_valid_o); end
    ramp_beat(6, 1'b0); clk_cycle();
    idle_inputs();
    checks++; if (dat_valid_o !== 1'b1 || dat_o !== ramp_word(5, 6)) begin
      failures++; $display("FAIL rstmid_word valid=%b got=%h exp=%h", dat_valid_o, dat_o, ramp_word(5, 6)); end
  endtask

  task automatic test_random();
    logic [W-1:0] exp_d;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      dat_valid_i = ($urandom_range(0, 9) < 7);
      sync_i      = dat_valid_i && ($urandom_range(0, 9) == 0);
      dat_ready_i = ($urandom_range(0, 1) == 1);
      clr_i       = ($urandom_range(0, 19) == 0);
      rst_i       = ($urandom_range(0, 199) == 0);
      for (int j = 0; j < NSAMPS; j++) dat_i[j] = INBITS'($urandom);
      clk_cycle();
      exp_d = (exp_q.size() != 0) ? exp_q[0] : m_last;
      checks++; if (dat_valid_o !== (exp_q.size() != 0)) begin failures++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, dat_valid_o, exp_q.size() != 0); end
      checks++; if (fill_o !== FW'(exp_q.size())) begin failures++; $display("FAIL rnd_fill c=%0d got=%0d exp=%0d", c, fill_o, exp_q.size()); end
      checks++; if (dat_o !== exp_d) begin failures++; $display("FAIL rnd_dat c=%0d got=%h exp=%h", c, dat_o, exp_d); end
      checks++; if (overflow_o !== m_ovf || misalign_o !== m_mis) begin
        failures++; $display("FAIL rnd_flags c=%0d got=%b%b exp=%b%b", c, overflow_o, misalign_o, m_ovf, m_mis); end
    end
    rst_i = 1'b0;
    idle_inputs();
  endtask

  // Test sequence and final report.
  initial begin
    #2;
    test_reset();
    test_ramp();
    test_saturation();
    test_backpressure();
    test_misalign();
    test_full_simul_read();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
